sad_search_ctrl: RTL and testbench
==================================

// Module: sad_search_ctrl
// PURPOSE
//   Sequences the pipelined 32-pixel SAD datapath over a block-matching search window.
//   Issues N candidate indices back-to-back, one per cycle.
//   Tracks in-flight results through the fixed-latency pipeline.
//   Keeps the minimum SAD and its candidate index, then reports through a done/ack handshake.
//   Sits between the candidate-block fetch logic and the SAD core.
// PARAMETERS
//   WIDTH     8   pixel width; SAD result width is WIDTH+5
//   PIPE_LAT  3   cycles from issue (candidate on SAD inputs) to its out_sad being valid
//   IDX_W     6   candidate index width; max N = 2**IDX_W-1
// PORTS
//   clk       in   1         clock, all logic on posedge
//   rst       in   1         synchronous, active-high reset
//   init      in   1         start request, sampled only in IDLE
//   num_cand  in   IDX_W     N, number of candidates; sampled with init
//   ack       in   1         host acknowledges result, sampled only in DONE
//   sad_in    in   WIDTH+5   out_sad from SAD core
//   issue     out  1         candidate cand_addr is presented to SAD core this cycle
//   cand_addr out  IDX_W     candidate index being issued
//   busy      out  1         high in ISSUE and DRAIN
//   best_sad  out  WIDTH+5   minimum SAD found
//   best_idx  out  IDX_W     index of the minimum SAD
//   done      out  1         result valid, held until ack
// BEHAVIOUR
// - Reset values: every output is 0, except best_sad = all ones. State goes to IDLE and the tag line is cleared.
// - FSM states: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
// - IDLE
//   - init=1 and N>0: load N, cand_addr=0, best_sad=all ones, best_idx=0, then go to ISSUE.
//   - init=1 and N=0: go to DONE directly; best_sad stays all ones, best_idx=0.
// - ISSUE
//   - issue=1 every cycle; cand_addr increments by 1 per cycle.
//   - After the cycle with cand_addr=N-1, go to DRAIN; issue=0 from then on.
// - Tag line (PIPE_LAT deep)
//   - Shifts {issue, cand_addr} every cycle.
//   - sad_in is compared only when the tag output is valid; otherwise sad_in is ignored.
//   - Update best_sad and best_idx only when sad_in < best_sad (strict). On a tie, the earlier index wins.
// - DRAIN: go to DONE on the cycle after the last valid tag has been compared (tag line empty).
// - DONE
//   - done=1; best_sad and best_idx are frozen.
//   - ack=1 moves to IDLE on the next edge; done falls on that same edge.
// - Latency: done rises N+PIPE_LAT+1 cycles after the edge that samples init.
// - Ignored inputs:
//   - init outside IDLE, including init with ack in DONE; a new start needs init high in IDLE.
//   - ack outside DONE.
//   - num_cand changes after it has been sampled.
// - rst mid-operation: abort on the next edge, discard in-flight tags, return all outputs to reset values.
// - Width rules:
//   - sad_in is unsigned WIDTH+5 bits.
//   - cand_addr does not wrap; ISSUE ends at N-1 <= 2**IDX_W-2.
// STRUCTURE
// - sad_pkg (shared): state encoding localparams, SAD_W = WIDTH+5, SAD_MAX constant.
// - Sub-module sad_tag_pipe: parameterised PIPE_LAT-deep valid+index delay line with synchronous clear.
// - Top level: FSM, issue counter, min compare/update register.
// TESTING (PIPE_LAT=3, WIDTH=8)
// 1. Reset release: all outputs are 0 and best_sad=0x1FFF; holds while init=0.
// 2. N=4, sad_in for idx0..3 = 100,40,40,90
//    -> best_sad=40, best_idx=1 (tie keeps earlier index).
//    -> done rises 8 cycles after the init edge.
// 3. N=1, sad_in=0 -> best_sad=0, best_idx=0; done 5 cycles after init; issue high for exactly 1 cycle.
// 4. N=0 -> done high one cycle after the init edge, best_sad=0x1FFF, best_idx=0, issue never asserted.
// 5. rst asserted in cycle 2 of ISSUE (N=10), then init N=2 with sad 7,3
//    -> no stale updates; best_sad=3, best_idx=1.
// 6. Handshake checks:
//    -> done held for 5 cycles without ack; init pulses during ISSUE and DONE are ignored.
//    -> ack+init together in DONE -> IDLE; next init starts a new run.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD block-matching search controller:
// FSM state encoding, default pixel width and SAD result sizing.
package sad_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int WIDTH_DEF = 8;

  // 32 absolute differences summed need five extra bits of headroom.
  function automatic int sad_w(input int width);
    return width + 5;
  endfunction

  localparam int SAD_W = sad_w(WIDTH_DEF);
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

endpackage

// File: rtl/sad_search_ctrl_chk.sv
// Protocol properties of the search controller outputs.
module sad_search_ctrl_chk
  import sad_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input logic             clk,
  input logic             rst,
  input logic             issue,
  input logic [IDX_W-1:0] cand_addr,
  input logic             busy,
  input logic [SAD_W-1:0] best_sad,
  input logic             done
);

  a_issue_busy: assert property (@(posedge clk) disable iff (rst) issue |-> busy);

  a_done_idle: assert property (@(posedge clk) disable iff (rst) done |-> !busy);

  a_no_wrap: assert property (@(posedge clk) disable iff (rst) issue |-> (cand_addr != '1));

  a_reset_vals: assert property (@(posedge clk) disable iff (rst)
    $past(rst) |-> ((best_sad == SAD_MAX) && !done && !issue && !busy));

endmodule

// File: rtl/sad_tag_pipe.sv
// Fixed-depth valid+index delay line that follows each issued candidate
// through the SAD core so its result can be matched to its index.
module sad_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] idx [DEPTH];

  // Shift register; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/sad_search_ctrl.sv
// Issues N candidates back-to-back to the pipelined SAD core, keeps the
// minimum SAD with its index, and reports it through a done/ack handshake.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PIPE_LAT = 3,
  parameter int IDX_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic [IDX_W-1:0]        num_cand,
  input  logic                    ack,
  input  logic [sad_w(WIDTH)-1:0] sad_in,
  output logic                    issue,
  output logic [IDX_W-1:0]        cand_addr,
  output logic                    busy,
  output logic [sad_w(WIDTH)-1:0] best_sad,
  output logic [IDX_W-1:0]        best_idx,
  output logic                    done
);

  localparam int SW = sad_w(WIDTH);
  localparam logic [SW-1:0] BEST_INIT = {SW{1'b1}};

  logic [1:0]       state;
  logic [IDX_W-1:0] last_idx;
  logic             tag_valid;
  logic [IDX_W-1:0] tag_idx;
  logic             tag_busy;
  logic             better;

  sad_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_idx    (cand_addr),
    .out_valid (tag_valid),
    .out_idx   (tag_idx),
    .any_valid (tag_busy)
  );

  // Strict less-than keeps the earlier index on a tie.
  assign better = tag_valid && (sad_in < best_sad);

  // Sequencing FSM with the issue counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_idx  <= '0;
      issue     <= 1'b0;
      cand_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init) begin
            if (num_cand != '0) begin
              state     <= ST_ISSUE;
              last_idx  <= num_cand - IDX_W'(1);
              issue     <= 1'b1;
              cand_addr <= '0;
              busy      <= 1'b1;
            end else begin
              // Empty search: done appears one cycle later, from DONE itself.
              state     <= ST_DONE;
              cand_addr <= '0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cand_addr == last_idx) begin
            state <= ST_DRAIN;
            issue <= 1'b0;
          end else begin
            cand_addr <= cand_addr + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          // Tag line empty means the final result was compared last cycle.
          if (!tag_busy) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          issue <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Running minimum; a new start clears it before any result can arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= BEST_INIT;
      best_idx <= '0;
    end else if ((state == ST_IDLE) && init) begin
      best_sad <= BEST_INIT;
      best_idx <= '0;
    end else if (better) begin
      best_sad <= sad_in;
      best_idx <= tag_idx;
    end else begin
      best_sad <= best_sad;
      best_idx <= best_idx;
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl: directed vector table, hand-written
// reset/handshake sequences and randomized searches against a minimum model.
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int WIDTH = 8;
  localparam int PIPE_LAT = 3;
  localparam int IDX_W = 6;
  localparam int SW = WIDTH + 5;
  localparam logic [SW-1:0] SMAX = 13'h1FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic ack = 1'b0;
  logic [IDX_W-1:0] num_cand = '0;
  logic [SW-1:0] sad_in = '0;
  logic issue, busy, done;
  logic [IDX_W-1:0] cand_addr, best_idx;
  logic [SW-1:0] best_sad;

  int checks = 0;
  int errors = 0;

  // Candidate SAD values and a behavioural model of the SAD core pipeline.
  logic [SW-1:0] tab [64];
  logic core_v [PIPE_LAT+1] = '{default: 1'b0};
  logic [SW-1:0] core_s [PIPE_LAT+1] = '{default: '0};

  sad_search_ctrl #(.WIDTH(WIDTH), .PIPE_LAT(PIPE_LAT), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .init(init), .num_cand(num_cand), .ack(ack),
    .sad_in(sad_in), .issue(issue), .cand_addr(cand_addr), .busy(busy),
    .best_sad(best_sad), .best_idx(best_idx), .done(done)
  );

  sad_search_ctrl_chk #(.IDX_W(IDX_W)) chk_i (
    .clk(clk), .rst(rst), .issue(issue), .cand_addr(cand_addr),
    .busy(busy), .best_sad(best_sad), .done(done)
  );

  always #5 clk = ~clk;

  // SAD core: the value of a candidate issued in cycle c appears in cycle c+PIPE_LAT;
  // otherwise small junk values that would win if they were not ignored.
  always @(negedge clk) begin
    for (int i = PIPE_LAT; i > 0; i--) begin
      core_v[i] = core_v[i-1];
      core_s[i] = core_s[i-1];
    end
    core_v[0] = issue;
    core_s[0] = tab[cand_addr];
    sad_in = core_v[PIPE_LAT] ? core_s[PIPE_LAT] : SW'($urandom_range(0, 3));
  end

  typedef struct {
    int n;
    logic [SW-1:0] s [4];
    logic [SW-1:0] es;
    int ei;
    int el;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_best(input int n, output logic [SW-1:0] bs, output int bi);
    bs = SMAX;
    bi = 0;
    for (int k = 0; k < n; k++) begin
      if (tab[k] < bs) begin
        bs = tab[k];
        bi = k;
      end
    end
  endfunction

  // Start a search of n candidates; returns cycles from the init edge to done.
  task automatic run(input int n, input bit poke, output int lat, output int nissue);
    int c;
    @(negedge clk);
    init = 1'b1;
    num_cand = IDX_W'(n);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    num_cand = IDX_W'($urandom);
    lat = -1;
    nissue = 0;
    c = 0;
    while (lat < 0 && c < 300) begin
      if (issue) begin
        chk("cand_addr", 32'(cand_addr), 32'(nissue));
        nissue++;
      end
      if (done) begin
        lat = c;
      end else begin
        chk("busy_run", 32'(busy), (n > 0) ? 32'd1 : 32'd0);
        if (poke && c == 2) begin
          init = 1'b1;
          ack = 1'b1;
          num_cand = IDX_W'(1);
        end else begin
          init = 1'b0;
          ack = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    init = 1'b0;
    ack = 1'b0;
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Hold done without ack (with a stray init), then ack together with init.
  task automatic hold_ack(input int cycles, input logic [SW-1:0] es, input int ei);
    for (int k = 0; k < cycles; k++) begin
      chk("done_hold", 32'(done), 32'd1);
      chk("sad_frozen", 32'(best_sad), 32'(es));
      chk("idx_frozen", 32'(best_idx), 32'(ei));
      init = (k == 1);
      @(negedge clk);
    end
    init = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    init = 1'b0;
    ack = 1'b0;
    chk("done_after_ack", 32'(done), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
    @(negedge clk);
    chk("no_restart", 32'(issue), 32'd0);
  endtask

  task automatic do_case(input string name, input int n, input bit poke, input int hold,
                         input logic [SW-1:0] es, input int ei, input int el);
    int lat, nis;
    run(n, poke, lat, nis);
    chk({name, "_latency"}, 32'(lat), 32'(el));
    chk({name, "_issues"}, 32'(nis), 32'(n));
    chk({name, "_best_sad"}, 32'(best_sad), 32'(es));
    chk({name, "_best_idx"}, 32'(best_idx), 32'(ei));
    hold_ack(hold, es, ei);
  endtask

  initial begin
    logic [SW-1:0] es;
    int ei, n;

    vecs[0] = '{n: 4, s: '{13'd100, 13'd40, 13'd40, 13'd90}, es: 13'd40, ei: 1, el: 8};
    vecs[1] = '{n: 1, s: '{13'd0, 13'd9, 13'd9, 13'd9}, es: 13'd0, ei: 0, el: 5};
    vecs[2] = '{n: 0, s: '{13'd5, 13'd5, 13'd5, 13'd5}, es: 13'h1FFF, ei: 0, el: 1};
    vecs[3] = '{n: 3, s: '{13'h1FFF, 13'h1FFF, 13'h1FFF, 13'd0}, es: 13'h1FFF, ei: 0, el: 7};
    vecs[4] = '{n: 4, s: '{13'd90, 13'd80, 13'd70, 13'd60}, es: 13'd60, ei: 3, el: 8};
    vecs[5] = '{n: 2, s: '{13'd5, 13'd5, 13'd0, 13'd0}, es: 13'd5, ei: 0, el: 6};
    for (int i = 0; i < 64; i++) tab[i] = '0;

    // Reset release: outputs at reset values while init stays low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_issue", 32'(issue), 32'd0);
      chk("rst_addr", 32'(cand_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sad", 32'(best_sad), 32'(SMAX));
      chk("rst_idx", 32'(best_idx), 32'd0);
    end

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) tab[i] = vecs[v].s[i];
      do_case($sformatf("vec%0d", v), vecs[v].n, 1'b0, 2, vecs[v].es, vecs[v].ei, vecs[v].el);
    end

    // Reset in the second ISSUE cycle of a 10-candidate run; stale results must not land.
    for (int i = 0; i < 10; i++) tab[i] = 13'd1;
    @(negedge clk);
    init = 1'b1;
    num_cand = IDX_W'(10);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_issue", 32'(issue), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(cand_addr), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("abort_sad", 32'(best_sad), 32'(SMAX));
      chk("abort_idx", 32'(best_idx), 32'd0);
      @(negedge clk);
    end
    tab[0] = 13'd7;
    tab[1] = 13'd3;
    do_case("after_rst", 2, 1'b0, 2, 13'd3, 1, 6);

    // Stray init and ack during ISSUE, and a long wait for ack.
    for (int i = 0; i < 6; i++) tab[i] = 13'(60 - 5 * i);
    tab[3] = 13'd20;
    do_case("poke", 6, 1'b1, 5, 13'd20, 3, 10);

    // Randomized searches, including the largest N.
    for (int r = 0; r < 16; r++) begin
      n = (r == 15) ? 63 : int'($urandom_range(1, 40));
      for (int i = 0; i < 64; i++) begin
        tab[i] = (r % 2 == 0) ? SW'($urandom_range(0, 15)) : SW'($urandom);
      end
      ref_best(n, es, ei);
      do_case($sformatf("rand%0d", r), n, (r % 3 == 0), 2, es, ei, n + PIPE_LAT + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
